// File: rtl/audio_i2s_pkg.sv
// Shared definitions for the I2S transmitter: frame geometry, FSM states
// and the FIFO level width helper.
package audio_i2s_pkg;

   localparam int FRAME_BITS = 64;
   localparam int SLOT_BITS  = 32;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Occupancy counter width: must be able to hold the value DEPTH itself.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous stereo-sample FIFO with first-word fall-through read data.
// A pop on an empty FIFO is ignored; a push on a full FIFO is ignored.
// flush_i empties the FIFO and takes priority over push/pop.
module audio_sample_fifo
   import audio_i2s_pkg::*;
#(
   parameter int WIDTH = 48,
   parameter int DEPTH = 8,
   parameter int LVL_W = level_w(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [LVL_W-1:0] level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             do_push, do_pop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // Storage array: written on accepted pushes only, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      level_q <= level_q + 1'b1;
         else if (do_pop && !do_push) level_q <= level_q - 1'b1;
      end
   end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter clocked by the audio PLL MCLK. Derives BCLK/LRCLK from
// MCLK, buffers stereo samples in a FIFO and shifts them out MSB-first with
// the standard 1-BCLK delay, 32 BCLKs per channel.
// Optional build macro AUDIO_I2S_UNDERRUN_REPEAT_EN: an underrun frame repeats
// the last popped sample instead of sending zeros.
// Handshake: a sample is taken on any clock where in_valid && in_ready;
// in_ready does not depend on in_valid, and in_valid may be raised freely.
module audio_i2s_tx
   import audio_i2s_pkg::*;
#(
   parameter int DATA_W     = 24,
   parameter int FIFO_DEPTH = 8,
   parameter int BCLK_DIV   = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          pll_locked,
   input  logic                          enable,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             in_left,
   input  logic [DATA_W-1:0]             in_right,
   output logic                          i2s_bclk,
   output logic                          i2s_lrclk,
   output logic                          i2s_dout,
   output logic                          underrun,
   output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
   output state_t                        dbg_state_o
);

   localparam int LVL_W = level_w(FIFO_DEPTH);
   localparam int DIV_W = $clog2(BCLK_DIV);

   state_t              state_q, state_d;
   logic                lock_meta_q, lock_sync_q;
   logic [DIV_W-1:0]    divcnt_q, divcnt_d;
   logic [5:0]          bitcnt_q, bitcnt_d;
   logic [DATA_W-1:0]   left_q, left_d, right_q, right_d, word_sel;
   logic                bclk_q, bclk_d, lrclk_q, lrclk_d, dout_q, dout_d;
   logic                underrun_q, underrun_d;
   logic                load, pop, push, flush;
   logic                fifo_empty, fifo_full;
   logic [2*DATA_W-1:0] fifo_rdata;
`ifdef AUDIO_I2S_UNDERRUN_REPEAT_EN
   logic [2*DATA_W-1:0] last_q, last_d;
`endif

   assign flush       = !lock_sync_q;
   assign in_ready    = lock_sync_q && !fifo_full;
   assign push        = in_valid && in_ready;
   assign i2s_bclk    = bclk_q;
   assign i2s_lrclk   = lrclk_q;
   assign i2s_dout    = dout_q;
   assign underrun    = underrun_q;
   assign dbg_state_o = state_q;

   audio_sample_fifo #(
      .WIDTH (2*DATA_W),
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush_i (flush),
      .push_i  (push),
      .wdata_i ({in_left, in_right}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .level_o (fifo_level)
   );

   // Two-flop synchroniser for the asynchronous PLL lock flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
      end else begin
         lock_meta_q <= pll_locked;
         lock_sync_q <= lock_meta_q;
      end
   end

   // Next state: counters, frame load from the FIFO, and the output bits for
   // the counter values being entered, so outputs line up with divcnt/bitcnt.
   always_comb begin
      state_d    = state_q;
      divcnt_d   = divcnt_q;
      bitcnt_d   = bitcnt_q;
      left_d     = left_q;
      right_d    = right_q;
      load       = 1'b0;
      pop        = 1'b0;
      underrun_d = 1'b0;
      bclk_d     = 1'b0;
      lrclk_d    = 1'b0;
      dout_d     = 1'b0;
      word_sel   = '0;
`ifdef AUDIO_I2S_UNDERRUN_REPEAT_EN
      last_d     = flush ? '0 : last_q;
`endif
      case (state_q)
         IDLE: begin
            if (lock_sync_q && enable) begin
               state_d  = RUN;
               divcnt_d = '0;
               bitcnt_d = '0;
               load     = 1'b1;
            end
         end
         RUN: begin
            if (!lock_sync_q) begin
               state_d = IDLE;
            end else if (divcnt_q == DIV_W'(BCLK_DIV - 1)) begin
               // BCLK falling edge: advance the bit counter or close the frame.
               divcnt_d = '0;
               if (bitcnt_q == 6'(FRAME_BITS - 1)) begin
                  if (enable) begin
                     bitcnt_d = '0;
                     load     = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bitcnt_d = bitcnt_q + 1'b1;
               end
            end else begin
               divcnt_d = divcnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         if (!fifo_empty) begin
            pop               = 1'b1;
            {left_d, right_d} = fifo_rdata;
`ifdef AUDIO_I2S_UNDERRUN_REPEAT_EN
            last_d            = fifo_rdata;
`endif
         end else begin
            underrun_d        = 1'b1;
`ifdef AUDIO_I2S_UNDERRUN_REPEAT_EN
            {left_d, right_d} = last_q;
`else
            {left_d, right_d} = '0;
`endif
         end
      end

      if (state_d == RUN) begin
         bclk_d   = (divcnt_d >= DIV_W'(BCLK_DIV / 2));
         lrclk_d  = bitcnt_d[5];
         word_sel = bitcnt_d[5] ? right_d : left_d;
         // Slot s in 1..DATA_W carries word bit DATA_W-s; slot 0 and the tail are 0.
         for (int b = 0; b < DATA_W; b++) begin
            if (bitcnt_d[4:0] == 5'(DATA_W - b)) dout_d = word_sel[b];
         end
      end
   end

   // State, counters, shift data and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         divcnt_q   <= '0;
         bitcnt_q   <= '0;
         left_q     <= '0;
         right_q    <= '0;
         bclk_q     <= 1'b0;
         lrclk_q    <= 1'b0;
         dout_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         divcnt_q   <= divcnt_d;
         bitcnt_q   <= bitcnt_d;
         left_q     <= left_d;
         right_q    <= right_d;
         bclk_q     <= bclk_d;
         lrclk_q    <= lrclk_d;
         dout_q     <= dout_d;
         underrun_q <= underrun_d;
      end
   end

`ifdef AUDIO_I2S_UNDERRUN_REPEAT_EN
   // Last sample popped from the FIFO, cleared when the lock drops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) last_q <= '0;
      else          last_q <= last_d;
   end
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: table of samples for the FIFO-fill test,
// whole-frame captures compared against patterns built from the I2S format.
module tb_audio_i2s_tx;
   import audio_i2s_pkg::*;

   localparam int DW  = 24;
   localparam int FD  = 8;
   localparam int LVW = 4;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic           pll_locked = 1'b0;
   logic           enable = 1'b0;
   logic           in_valid = 1'b0;
   logic [DW-1:0]  in_left = '0;
   logic [DW-1:0]  in_right = '0;
   logic           in_ready, i2s_bclk, i2s_lrclk, i2s_dout, underrun;
   logic [LVW-1:0] fifo_level;
   state_t         dbg_state;

   audio_i2s_tx #(.DATA_W(DW), .FIFO_DEPTH(FD), .BCLK_DIV(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pll_locked  (pll_locked),
      .enable      (enable),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_left     (in_left),
      .in_right    (in_right),
      .i2s_bclk    (i2s_bclk),
      .i2s_lrclk   (i2s_lrclk),
      .i2s_dout    (i2s_dout),
      .underrun    (underrun),
      .fifo_level  (fifo_level),
      .dbg_state_o (dbg_state)
   );

   int total = 0;
   int bad = 0;
   logic [2*DW-1:0] exp_q[$];

   typedef struct {
      logic [DW-1:0]  l;
      logic [DW-1:0]  r;
      logic           exp_ready;
      logic [LVW-1:0] exp_level;
   } vec_t;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // expected patterns for one 256-clock frame, index = clock within frame
   function automatic logic [255:0] bclk_pat();
      logic [255:0] v;
      for (int j = 0; j < 256; j++) v[j] = ((j % 4) >= 2);
      return v;
   endfunction

   function automatic logic [255:0] lr_pat();
      logic [255:0] v;
      for (int j = 0; j < 256; j++) v[j] = (j >= 128);
      return v;
   endfunction

   function automatic logic [255:0] dout_pat(input logic [2*DW-1:0] s);
      logic [255:0] v;
      logic [DW-1:0] w;
      int slot;
      logic b;
      v = '0;
      for (int k = 0; k < 64; k++) begin
         slot = k % 32;
         w = (k < 32) ? s[2*DW-1:DW] : s[DW-1:0];
         b = 1'b0;
         if (slot >= 1 && slot <= DW) b = w[DW-slot];
         for (int d = 0; d < 4; d++) v[4*k+d] = b;
      end
      return v;
   endfunction

   // capture one frame starting at the current negedge (j=0)
   task automatic capture(input int drop_at, output logic [255:0] vb, output logic [255:0] vl,
                          output logic [255:0] vd, output logic [255:0] vu, output logic [LVW-1:0] lvl0);
      for (int j = 0; j < 256; j++) begin
         if (j > 0) @(negedge clk);
         vb[j] = i2s_bclk;
         vl[j] = i2s_lrclk;
         vd[j] = i2s_dout;
         vu[j] = underrun;
         if (j == 0) lvl0 = fifo_level;
         if (j == drop_at) enable = 1'b0;
      end
   endtask

   task automatic check_frame(input string name, input int drop_at, input logic [2*DW-1:0] exp_s,
                              input logic exp_urun, input logic [LVW-1:0] exp_lvl);
      logic [255:0] vb, vl, vd, vu, eu;
      logic [LVW-1:0] lvl0;
      capture(drop_at, vb, vl, vd, vu, lvl0);
      eu = '0;
      eu[0] = exp_urun;
      check({name, "_bclk"}, vb, bclk_pat());
      check({name, "_lrclk"}, vl, lr_pat());
      check({name, "_dout"}, vd, dout_pat(exp_s));
      check({name, "_underrun"}, vu, eu);
      check({name, "_level"}, lvl0, exp_lvl);
   endtask

   task automatic check_idle(input string name, input logic [LVW-1:0] exp_lvl);
      check({name, "_state"}, dbg_state == RUN, 1'b0);
      check({name, "_outs"}, {i2s_bclk, i2s_lrclk, i2s_dout}, 3'b000);
      check({name, "_level"}, fifo_level, exp_lvl);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[9];
      logic acc;
      logic [2*DW-1:0] last_s, s;
      logic found;

      tbl[0] = '{24'h123456, 24'h654321, 1'b1, 4'd1};
      tbl[1] = '{24'hABCDEF, 24'hFEDCBA, 1'b1, 4'd2};
      tbl[2] = '{24'h800001, 24'h7FFFFE, 1'b1, 4'd3};
      tbl[3] = '{24'h000001, 24'hFFFFFF, 1'b1, 4'd4};
      tbl[4] = '{24'h55AA55, 24'hAA55AA, 1'b1, 4'd5};
      tbl[5] = '{24'h0F0F0F, 24'hF0F0F0, 1'b1, 4'd6};
      tbl[6] = '{24'h111111, 24'h222222, 1'b1, 4'd7};
      tbl[7] = '{24'h333333, 24'h444444, 1'b1, 4'd8};
      tbl[8] = '{24'hDEAD00, 24'h00BEEF, 1'b0, 4'd8};

      // reset values
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outs", {in_ready, i2s_bclk, i2s_lrclk, i2s_dout, underrun}, 5'b0);
      check("reset_level", fifo_level, 4'd0);
      reset_n = 1'b1;

      // 1: no lock -> nothing accepted, no activity
      acc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_left  = tbl[i].l;
         in_right = tbl[i].r;
         check("nolock_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         acc |= i2s_bclk | i2s_lrclk | i2s_dout | underrun | in_ready;
         @(negedge clk);
      end
      check("nolock_activity", acc, 1'b0);
      check_idle("nolock", 4'd0);

      // 2: lock, push one sample, enable, check a full frame
      enable = 1'b0;
      pll_locked = 1'b1;
      repeat (3) @(negedge clk);
      check("lock_ready", in_ready, 1'b1);
      s = {24'hA5A5A5, 24'h5A5A5A};
      in_valid = 1'b1;
      {in_left, in_right} = s;
      @(negedge clk);
      in_valid = 1'b0;
      exp_q.push_back(s);
      check("push1_level", fifo_level, 4'd1);
      enable = 1'b1;
      @(negedge clk);
      last_s = exp_q.pop_front();
      check_frame("f1", -1, last_s, 1'b0, 4'd0);

      // 4: FIFO empty -> underrun frame; enable dropped early so IDLE follows
      @(negedge clk);
`ifdef AUDIO_I2S_UNDERRUN_REPEAT_EN
      check_frame("f2_urun", 10, last_s, 1'b1, 4'd0);
`else
      check_frame("f2_urun", 10, '0, 1'b1, 4'd0);
`endif
      @(negedge clk);
      check_idle("f2_end", 4'd0);

      // 3: fill FIFO in IDLE from the table, 9th push refused
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_left  = tbl[i].l;
         in_right = tbl[i].r;
         check($sformatf("fill%0d_ready", i), in_ready, tbl[i].exp_ready);
         if (tbl[i].exp_ready) exp_q.push_back({tbl[i].l, tbl[i].r});
         @(negedge clk);
         check($sformatf("fill%0d_level", i), fifo_level, tbl[i].exp_level);
      end
      in_valid = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      check_frame("f3", -1, exp_q.pop_front(), 1'b0, 4'd7);
      @(negedge clk);
      check_frame("f4", -1, exp_q.pop_front(), 1'b0, 4'd6);

      // 6: drop enable at bitcnt 10 -> frame completes, FIFO retained
      @(negedge clk);
      check_frame("f5", 40, exp_q.pop_front(), 1'b0, 4'd5);
      @(negedge clk);
      check_idle("f5_end", 4'd5);
      @(negedge clk);
      check_idle("f5_hold", 4'd5);

      // 5: lock drop mid-frame -> IDLE within 3 clk, FIFO flushed
      enable = 1'b1;
      @(negedge clk);
      check("f6_run", dbg_state == RUN, 1'b1);
      check("f6_level", fifo_level, 4'd4);
      repeat (100) @(negedge clk);
      pll_locked = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("unlock", 4'd0);
      check("unlock_ready", in_ready, 1'b0);
      exp_q.delete();

      // relock: new frame from bitcnt 0, empty FIFO -> zeros and underrun
      pll_locked = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         found = (dbg_state == RUN);
      end
      check("relock_run", found, 1'b1);
      if (found) check_frame("f7_relock", -1, '0, 1'b1, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
